// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the CPU M-cycle/T-state sequencer.
// Optional build macro: MEM_HL_EN enables the (HL) memory load/store states.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_OPERAND = 3'd1,
    ST_HALT    = 3'd2
`ifdef MEM_HL_EN
    , ST_MEMRD = 3'd3,
    ST_MEMWR   = 3'd4
`endif
  } seq_state_e;

  localparam logic [1:0] T1 = 2'd0;
  localparam logic [1:0] T2 = 2'd1;
  localparam logic [1:0] T3 = 2'd2;
  localparam logic [1:0] T4 = 2'd3;

  localparam logic [2:0] REG_B = 3'd0;
  localparam logic [2:0] REG_C = 3'd1;
  localparam logic [2:0] REG_D = 3'd2;
  localparam logic [2:0] REG_E = 3'd3;
  localparam logic [2:0] REG_H = 3'd4;
  localparam logic [2:0] REG_L = 3'd5;
  localparam logic [2:0] REG_M = 3'd6;  // HL pair / memory operand
  localparam logic [2:0] REG_A = 3'd7;

  localparam logic [7:0] OP_HALT    = 8'h76;
  localparam logic [7:0] MASK_LD_RR = 8'hC0;
  localparam logic [7:0] PAT_LD_RR  = 8'h40;
  localparam logic [7:0] MASK_LD_RN = 8'hC7;
  localparam logic [7:0] PAT_LD_RN  = 8'h06;

  typedef enum logic [2:0] {
    K_NOP, K_LD_RR, K_LD_RN, K_HALT, K_LD_RM, K_LD_MR
  } instr_e;

  // Classify an opcode; anything unrecognised is treated as NOP.
  function automatic instr_e decode_op(input logic [7:0] op);
    instr_e k;
    k = K_NOP;
    if (op == OP_HALT) begin
      k = K_HALT;
    end else if ((op & MASK_LD_RR) == PAT_LD_RR) begin
      if (op[5:3] != REG_M && op[2:0] != REG_M) k = K_LD_RR;
`ifdef MEM_HL_EN
      else if (op[2:0] == REG_M) k = K_LD_RM;
      else k = K_LD_MR;
`endif
    end else if ((op & MASK_LD_RN) == PAT_LD_RN && op[5:3] != REG_M) begin
      k = K_LD_RN;
    end
    return k;
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Memory/register-file control bus between the sequencer and the datapath.
interface cpu_sequencer_if;
  logic [7:0] data_bus_in;
  logic       mem_rd;
  logic       mem_wr;
  logic       drive_addr;
  logic       inc_pc;
  logic [2:0] rd_sel;
  logic       rd_en;
  logic [2:0] wr_sel;
  logic       wr_en;
  logic       writeback;
  logic       data_src;

  modport master (
    input  data_bus_in,
    output mem_rd, mem_wr, drive_addr, inc_pc,
    output rd_sel, rd_en, wr_sel, wr_en, writeback, data_src
  );

  modport slave (
    output data_bus_in,
    input  mem_rd, mem_wr, drive_addr, inc_pc,
    input  rd_sel, rd_en, wr_sel, wr_en, writeback, data_src
  );
endinterface

// File: rtl/cpu_sequencer_tstate_counter.sv
// T-state counter: a 2-bit down-counter of remaining T-states in the M-cycle.
// Reset parks it at T4 so the first clock after reset starts a fresh T1.
module tstate_counter (
  input  logic       clk,
  input  logic       rst,
  output logic [1:0] tstate,
  output logic       m_end
);
  logic [1:0] remain;

  // Reload at terminal count, otherwise count down.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              remain <= 2'd0;
    else if (remain == 2'd0) remain <= 2'd3;
    else                   remain <= remain - 2'd1;
  end

  assign tstate = 2'd3 - remain;
  assign m_end  = (remain == 2'd0);
endmodule

// File: rtl/cpu_sequencer.sv
// CPU instruction sequencer: steps FETCH/OPERAND/HALT M-cycles and emits
// registered bus and register-file strobes for each T-state.
// Optional build macro: MEM_HL_EN adds LD r,(HL) and LD (HL),r.
//
// state      | meaning
// FETCH      | M1 opcode fetch, LD r,r executes in its T3-T4
// OPERAND    | immediate byte read for LD r,n
// MEMRD      | (MEM_HL_EN) read from (HL) into register
// MEMWR      | (MEM_HL_EN) write register to (HL)
// HALT       | idle until wake seen at T4
module cpu_sequencer
  import cpu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wake,
  output logic       m1t1,
  output logic [1:0] tstate,
  output logic       halted,
  cpu_sequencer_if.master bus
);
  seq_state_e state, nxt_state;
  logic [7:0] ir, ir_nxt;
  instr_e     kind;
  logic       m_end;
  logic [1:0] nxt_t;
  logic       m1t1_n, halted_n, mem_rd_n, mem_wr_n, drive_addr_n, inc_pc_n;
  logic       rd_en_n, wr_en_n, writeback_n, data_src_n;
  logic [2:0] rd_sel_n, wr_sel_n;
  logic       mem_rd_q, mem_wr_q, drive_addr_q, inc_pc_q;
  logic       rd_en_q, wr_en_q, writeback_q, data_src_q;
  logic [2:0] rd_sel_q, wr_sel_q;

  tstate_counter u_tstate (
    .clk    (clk),
    .rst    (rst),
    .tstate (tstate),
    .m_end  (m_end)
  );

  assign nxt_t = tstate + 2'd1;

  // Next state and the output set for the T-state about to begin.
  always_comb begin
    nxt_state    = state;
    ir_nxt       = ir;
    m1t1_n       = 1'b0;
    halted_n     = 1'b0;
    mem_rd_n     = 1'b0;
    mem_wr_n     = 1'b0;
    drive_addr_n = 1'b0;
    inc_pc_n     = 1'b0;
    rd_sel_n     = 3'd0;
    rd_en_n      = 1'b0;
    wr_sel_n     = 3'd0;
    wr_en_n      = 1'b0;
    writeback_n  = 1'b0;
    data_src_n   = 1'b0;
    // IR captures the opcode on the edge ending FETCH T2; T3 outputs need it now.
    if (state == ST_FETCH && tstate == T2) ir_nxt = bus.data_bus_in;
    kind = decode_op(ir_nxt);
    if (m_end) begin
      case (state)
        ST_FETCH: begin
          case (kind)
            K_LD_RN: nxt_state = ST_OPERAND;
            K_HALT:  nxt_state = ST_HALT;
`ifdef MEM_HL_EN
            K_LD_RM: nxt_state = ST_MEMRD;
            K_LD_MR: nxt_state = ST_MEMWR;
`endif
            default: nxt_state = ST_FETCH;
          endcase
        end
        ST_HALT: nxt_state = wake ? ST_FETCH : ST_HALT;
        default: nxt_state = ST_FETCH;
      endcase
    end
    case (nxt_state)
      ST_FETCH: begin
        if (nxt_t == T1) m1t1_n = 1'b1;
        if (nxt_t == T1 || nxt_t == T2) mem_rd_n = 1'b1;
        else if (kind == K_LD_RR) begin
          rd_sel_n    = ir_nxt[2:0];
          rd_en_n     = 1'b1;
          wr_sel_n    = ir_nxt[5:3];
          wr_en_n     = 1'b1;
          writeback_n = (nxt_t == T4);
        end
      end
      ST_OPERAND: begin
        if (nxt_t == T1 || nxt_t == T2) mem_rd_n = 1'b1;
        else begin
          wr_sel_n    = ir_nxt[5:3];
          wr_en_n     = 1'b1;
          data_src_n  = 1'b1;
          writeback_n = (nxt_t == T4);
          inc_pc_n    = (nxt_t == T4);
        end
      end
`ifdef MEM_HL_EN
      ST_MEMRD: begin
        if (nxt_t == T1 || nxt_t == T2) begin
          drive_addr_n = 1'b1;
          rd_sel_n     = REG_M;
          mem_rd_n     = 1'b1;
        end else begin
          wr_sel_n    = ir_nxt[5:3];
          wr_en_n     = 1'b1;
          data_src_n  = 1'b1;
          writeback_n = (nxt_t == T4);
        end
      end
      ST_MEMWR: begin
        if (nxt_t == T1 || nxt_t == T2) begin
          drive_addr_n = 1'b1;
          rd_sel_n     = REG_M;
        end else begin
          rd_sel_n = ir_nxt[2:0];
          rd_en_n  = 1'b1;
          mem_wr_n = 1'b1;
        end
      end
`endif
      ST_HALT: halted_n = 1'b1;
      default: ;
    endcase
  end

  // Register state, IR and all outputs; reset aborts the instruction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_FETCH;
      ir           <= 8'h00;
      m1t1         <= 1'b0;
      halted       <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      drive_addr_q <= 1'b0;
      inc_pc_q     <= 1'b0;
      rd_sel_q     <= 3'd0;
      rd_en_q      <= 1'b0;
      wr_sel_q     <= 3'd0;
      wr_en_q      <= 1'b0;
      writeback_q  <= 1'b0;
      data_src_q   <= 1'b0;
    end else begin
      state        <= nxt_state;
      ir           <= ir_nxt;
      m1t1         <= m1t1_n;
      halted       <= halted_n;
      mem_rd_q     <= mem_rd_n;
      mem_wr_q     <= mem_wr_n;
      drive_addr_q <= drive_addr_n;
      inc_pc_q     <= inc_pc_n;
      rd_sel_q     <= rd_sel_n;
      rd_en_q      <= rd_en_n;
      wr_sel_q     <= wr_sel_n;
      wr_en_q      <= wr_en_n;
      writeback_q  <= writeback_n;
      data_src_q   <= data_src_n;
    end
  end

  assign bus.mem_rd     = mem_rd_q;
  assign bus.mem_wr     = mem_wr_q;
  assign bus.drive_addr = drive_addr_q;
  assign bus.inc_pc     = inc_pc_q;
  assign bus.rd_sel     = rd_sel_q;
  assign bus.rd_en      = rd_en_q;
  assign bus.wr_sel     = wr_sel_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.writeback  = writeback_q;
  assign bus.data_src   = data_src_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: reset, LD r,r, LD r,n, NOP decodes,
// HALT/wake and reset abort during an operand cycle.
module tb_cpu_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wake = 1'b0;
  logic       m1t1, halted;
  logic [1:0] tstate;
  int total = 0;
  int bad = 0;
  int wb_edges = 0;
  int wb_mark;

  cpu_sequencer_if bus_if ();

  cpu_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .wake   (wake),
    .m1t1   (m1t1),
    .tstate (tstate),
    .halted (halted),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  // Count writeback rising edges (register file latches on them).
  always @(posedge bus_if.writeback) wb_edges++;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus_if.data_bus_in = 8'h00;
    #1;
    chk("rst_m1t1", m1t1, 0);
    chk("rst_mem_rd", bus_if.mem_rd, 0);
    chk("rst_wr_en", bus_if.wr_en, 0);
    chk("rst_halted", halted, 0);
    chk("rst_tstate", tstate, 3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // LD A,B
    bus_if.data_bus_in = 8'h78;
    step();
    chk("first_tstate", tstate, 0);
    chk("first_m1t1", m1t1, 1);
    chk("first_mem_rd", bus_if.mem_rd, 1);
    chk("first_drive_addr", bus_if.drive_addr, 0);
    wb_mark = wb_edges;
    step();
    chk("ldrr_t2_m1t1", m1t1, 0);
    chk("ldrr_t2_mem_rd", bus_if.mem_rd, 1);
    step();
    chk("ldrr_t3_rd_sel", bus_if.rd_sel, 0);
    chk("ldrr_t3_wr_sel", bus_if.wr_sel, 7);
    chk("ldrr_t3_wr_en", bus_if.wr_en, 1);
    chk("ldrr_t3_rd_en", bus_if.rd_en, 1);
    chk("ldrr_t3_data_src", bus_if.data_src, 0);
    chk("ldrr_t3_writeback", bus_if.writeback, 0);
    step();
    chk("ldrr_t4_writeback", bus_if.writeback, 1);
    chk("ldrr_t4_wr_en", bus_if.wr_en, 1);
    chk("ldrr_t4_rd_sel", bus_if.rd_sel, 0);
    step();
    chk("ldrr_next_m1t1", m1t1, 1);
    chk("ldrr_next_writeback", bus_if.writeback, 0);
    chk("ldrr_next_wr_en", bus_if.wr_en, 0);
    chk("ldrr_wb_count", wb_edges - wb_mark, 1);

    // LD A,n with n=0x5A
    bus_if.data_bus_in = 8'h3E;
    step();
    step();
    chk("ldn_m1_t3_wr_en", bus_if.wr_en, 0);
    step();
    chk("ldn_m1_t4_writeback", bus_if.writeback, 0);
    bus_if.data_bus_in = 8'h5A;
    step();
    chk("ldn_m2_t1_m1t1", m1t1, 0);
    chk("ldn_m2_t1_mem_rd", bus_if.mem_rd, 1);
    chk("ldn_m2_t1_drive_addr", bus_if.drive_addr, 0);
    step();
    chk("ldn_m2_t2_mem_rd", bus_if.mem_rd, 1);
    step();
    chk("ldn_m2_t3_wr_en", bus_if.wr_en, 1);
    chk("ldn_m2_t3_wr_sel", bus_if.wr_sel, 7);
    chk("ldn_m2_t3_data_src", bus_if.data_src, 1);
    chk("ldn_m2_t3_inc_pc", bus_if.inc_pc, 0);
    chk("ldn_m2_t3_writeback", bus_if.writeback, 0);
    step();
    chk("ldn_m2_t4_inc_pc", bus_if.inc_pc, 1);
    chk("ldn_m2_t4_writeback", bus_if.writeback, 1);
    chk("ldn_m2_t4_data_src", bus_if.data_src, 1);
    step();
    chk("ldn_next_m1t1", m1t1, 1);
    chk("ldn_next_inc_pc", bus_if.inc_pc, 0);

    // 0x70 with wake held high outside HALT
    bus_if.data_bus_in = 8'h70;
    wake = 1'b1;
    step();
    step();
    chk("op70_t3_wr_en", bus_if.wr_en, 0);
    chk("op70_t3_mem_wr", bus_if.mem_wr, 0);
    step();
    chk("op70_t4_writeback", bus_if.writeback, 0);
    chk("op70_t4_halted", halted, 0);
    step();
`ifdef MEM_HL_EN
    chk("memwr_t1_m1t1", m1t1, 0);
    chk("memwr_t1_drive_addr", bus_if.drive_addr, 1);
    chk("memwr_t1_rd_sel", bus_if.rd_sel, 6);
    chk("memwr_t1_mem_rd", bus_if.mem_rd, 0);
    step();
    chk("memwr_t2_drive_addr", bus_if.drive_addr, 1);
    chk("memwr_t2_rd_sel", bus_if.rd_sel, 6);
    step();
    chk("memwr_t3_rd_sel", bus_if.rd_sel, 0);
    chk("memwr_t3_rd_en", bus_if.rd_en, 1);
    chk("memwr_t3_mem_wr", bus_if.mem_wr, 1);
    chk("memwr_t3_mem_rd", bus_if.mem_rd, 0);
    step();
    chk("memwr_t4_mem_wr", bus_if.mem_wr, 1);
    chk("memwr_t4_writeback", bus_if.writeback, 0);
    step();
`endif
    chk("op70_next_m1t1", m1t1, 1);
    chk("op70_next_mem_wr", bus_if.mem_wr, 0);
    chk("op70_next_halted", halted, 0);
    wake = 1'b0;

    // 0x36 (LD (HL),n) is not decoded
    bus_if.data_bus_in = 8'h36;
    step();
    step();
    chk("op36_t3_wr_en", bus_if.wr_en, 0);
    step();
    step();
    chk("op36_next_m1t1", m1t1, 1);

    // HALT for 10 M-cycles, early wake ignored, then wake at T4
    bus_if.data_bus_in = 8'h76;
    step();
    step();
    step();
    step();
    chk("halt_t1_halted", halted, 1);
    chk("halt_t1_m1t1", m1t1, 0);
    chk("halt_t1_tstate", tstate, 0);
    for (int k = 1; k <= 39; k++) begin
      wake = (k == 18);
      step();
      wake = 1'b0;
      chk("halt_hold_m1t1", m1t1, 0);
      chk("halt_hold_halted", halted, 1);
      chk("halt_hold_mem_rd", bus_if.mem_rd, 0);
      chk("halt_hold_writeback", bus_if.writeback, 0);
    end
    chk("halt_end_tstate", tstate, 3);
    wake = 1'b1;
    step();
    wake = 1'b0;
    chk("wake_tstate", tstate, 0);
    chk("wake_m1t1", m1t1, 1);
    chk("wake_halted", halted, 0);

    // LD B,n aborted by reset in M2 T3
    bus_if.data_bus_in = 8'h06;
    step();
    step();
    step();
    bus_if.data_bus_in = 8'h11;
    step();
    step();
    step();
    chk("abort_pre_wr_en", bus_if.wr_en, 1);
    chk("abort_pre_wr_sel", bus_if.wr_sel, 0);
    wb_mark = wb_edges;
    #2;
    rst = 1'b0;
    #1;
    chk("abort_wr_en", bus_if.wr_en, 0);
    chk("abort_writeback", bus_if.writeback, 0);
    chk("abort_data_src", bus_if.data_src, 0);
    chk("abort_mem_rd", bus_if.mem_rd, 0);
    chk("abort_tstate", tstate, 3);
    @(posedge clk);
    #1;
    chk("abort_t4_writeback", bus_if.writeback, 0);
    chk("abort_wb_edges", wb_edges - wb_mark, 0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("rerun_tstate", tstate, 0);
    chk("rerun_m1t1", m1t1, 1);
    chk("rerun_mem_rd", bus_if.mem_rd, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
